fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter, drives the word address into the instruction RAM, and registers the fetched word into the IF/ID pipeline register consumed by the ID stage. Handles stall, flush and branch/jump redirect from downstream. Detects the halt word, then counts the pipeline drain cycles before flagging completion to the testbench.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address loaded into PC on reset; bits [1:0] must be 0.
- `HALT_INSTR`, default 32'hFFFF_FFFF: instruction word that terminates fetch.
- `DRAIN_CYCLES`, default 4: unstalled cycles after halt detection before `done` rises; legal range 1..15.

- `CLK` input 1: single clock; all state updates on posedge.
- `RESET` input 1: synchronous, active-high; sampled on posedge CLK.
- `stall` input 1: hold PC and IF/ID contents (load-use hazard from ID).
- `flush` input 1: load a bubble into IF/ID on this edge.
- `redirect_valid` input 1: a taken branch/jump resolved downstream.
- `redirect_pc` input 32: target byte address; bits [1:0] ignored and treated as 0.
- `imem_addr` output 32: word address to instruction RAM, equal to `{2'b00, pc[31:2]}`.
- `imem_data` input 32: instruction word at `imem_addr`, valid combinationally in the same cycle.
- `if_id_instr` output 32: registered instruction to ID.
- `if_id_pc4` output 32: registered PC+4 of that instruction.
- `if_id_valid` output 1: IF/ID holds a real instruction.
- `halted` output 1: halt word detected and fetch is frozen (DRAIN or DONE).
- `done` output 1: drain complete; sticky until RESET.

## Operation
- States: RUN, DRAIN, DONE. Reset enters RUN.
- Bubble: `if_id_instr`=0 (nop), `if_id_pc4`=0, `if_id_valid`=0.
- Per-edge priority: RESET > redirect_valid > flush > stall > normal fetch.
- RESET: pc=RESET_PC, IF/ID=bubble, state=RUN, drain counter=0. `halted`=0 and `done`=0.
- redirect_valid, any state except DONE:
  - pc={redirect_pc[31:2],2'b00} and IF/ID=bubble.
  - Taken regardless of stall or flush.
  - From DRAIN, returns to RUN and clears `halted`, cancelling a halt fetched on the wrong path.
- flush without redirect:
  - IF/ID=bubble and pc=pc+4. The word fetched this cycle is discarded.
  - A halt word is not recognised in that cycle.
- stall, RUN: pc and IF/ID unchanged.
- Normal fetch, RUN, imem_data≠HALT_INSTR: if_id_instr=imem_data, if_id_pc4=pc+4, if_id_valid=1, pc=pc+4.
- Halt fetch, RUN, no stall/flush/redirect, imem_data==HALT_INSTR:
  - IF/ID=bubble. The halt word is never passed downstream.
  - pc unchanged. Counter=DRAIN_CYCLES. State=DRAIN.
- DRAIN:
  - pc frozen and IF/ID=bubble every edge.
  - Counter decrements on each edge where stall=0; flush has no effect.
  - When the counter is 1 and stall=0, the next state is DONE.
- DONE: everything frozen, `done`=1. Redirect, flush and stall are ignored. Only RESET exits.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC+4 wraps to 0 with no flag.

## Timing
- One-cycle fetch latency: word at pc appears on `if_id_instr` after the next posedge.
- `imem_addr` is combinational from the pc register and changes only after a posedge.
- Redirect penalty: the edge sampling redirect_valid loads the bubble. The target instruction reaches IF/ID one edge later.
- `halted` rises on the edge that enters DRAIN.
- `done` rises exactly DRAIN_CYCLES unstalled edges after `halted`.
- All outputs are registered except `imem_addr`. Reset values take effect on the first posedge with RESET=1.
- RESET mid-DRAIN or in DONE: the next edge is in RUN at RESET_PC with both flags low.

## Test plan
- Sequential fetch: RAM words 0..3 = 0x20010001, 0x20020002, 0x00221820, 0x00000000; RESET then run 4 edges -> if_id_instr follows the sequence; if_id_pc4 = 4, 8, 12, 16; valid=1.
- Stall/flush: assert stall for 2 edges at pc=8 -> IF/ID holds 0x20020002 with pc4=8 and pc stays 8. Then flush 1 edge -> bubble, pc=12.
- Redirect during stall: stall=1, redirect_valid=1, redirect_pc=0x43 -> pc=0x40, bubble; next edge if_id_pc4=0x44.
- Halt and drain: word at 0x10 = 0xFFFFFFFF, DRAIN_CYCLES=4, one stall cycle inside DRAIN -> halted rises when pc=0x10, done rises 5 edges later, pc stays 0x10, IF/ID bubbles throughout.
- Halt cancel: redirect_valid in the 2nd DRAIN cycle to 0x20 -> halted=0, state RUN, fetch resumes at 0x20, done never rises.
- Wrap and reset: RESET_PC=0xFFFFFFFC -> after one edge pc=0, if_id_pc4=0. Assert RESET in DONE -> done=0 and pc=RESET_PC on the next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from instruction RAM into IF/ID,
// and handles stall, flush, redirect and halt detection with a drain countdown.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        done
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               halted_q, halted_d;
  logic               done_q, done_d;
  logic [31:0]        pc_plus4_c;
  logic [31:0]        target_c;

  assign pc_plus4_c = pc_q + 32'd4;
  assign target_c   = redirect_pc & ~32'd3;

  // State and pipeline register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      pc4_q    <= 32'd0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      done_q   <= done_d;
    end
  end

  // Next-state: redirect > flush > stall > fetch; DONE freezes everything
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    done_d   = done_q;

    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_d    = target_c;
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else if (flush) begin
          pc_d    = pc_plus4_c;
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (imem_data == HALT_INSTR) begin
          // Halt word is swallowed; pc stays on it while the pipe drains
          instr_d  = 32'd0;
          pc4_d    = 32'd0;
          valid_d  = 1'b0;
          cnt_d    = CNT_LOAD;
          halted_d = 1'b1;
          state_d  = DRAIN;
        end else begin
          pc_d    = pc_plus4_c;
          instr_d = imem_data;
          pc4_d   = pc_plus4_c;
          valid_d = 1'b1;
        end
      end
      DRAIN: begin
        instr_d = 32'd0;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
        if (redirect_valid) begin
          pc_d     = target_c;
          cnt_d    = '0;
          halted_d = 1'b0;
          state_d  = RUN;
        end else if (!stall) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign imem_addr   = {2'b00, pc_q[31:2]};
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign halted      = halted_q;
  assign done        = done_q;

endmodule
